moddiv_engine: RTL and testbench

MODDIV_ENGINE -- requirements
Module: moddiv_engine

---
 rtl/moddiv_pkg.sv | 30 +++
 rtl/moddiv_if.sv | 37 +++
 rtl/moddiv_addsub.sv | 34 +++
 rtl/moddiv_engine.sv | 173 +++++++++++++++++
 tb/tb_moddiv_engine.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/moddiv_pkg.sv
// moddiv_pkg -- shared types and sizing for the modular-division engine.
//   state_t      : controller states, also exported on the debug port
//   step_t       : which single LOOP step the datapath performs this cycle
//   DATA_LEN_DEF : default operand/modulus width
//   iter_max()   : LOOP-cycle watchdog limit derived from the width
package moddiv_pkg;

    localparam int DATA_LEN_DEF = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_LOOP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STEP_HALVE_U = 2'd0,
        STEP_HALVE_V = 2'd1,
        STEP_SUB_U   = 2'd2,
        STEP_SUB_V   = 2'd3
    } step_t;

    // Binary inversion shrinks U+V by at least one bit every two steps,
    // so four steps per operand bit is a safe ceiling.
    function automatic int iter_max(input int data_len);
        return 4 * data_len;
    endfunction

endpackage

// File: rtl/moddiv_if.sv
// moddiv_if -- request/response bundle of the modular-division engine.
//   start, abort, a, b, p : requester -> engine
//   result, busy, done, err, state_dbg : engine -> requester
//
// Handshake: a request is taken when start is high while the engine is
// idle (busy low and done low); a, b and p are captured on that cycle.
// There is no back-pressure on the response: done is a one-cycle pulse,
// err qualifies it, and result/err hold until the next accepted start.
// state_dbg mirrors the controller state for observation only.
interface moddiv_if
    import moddiv_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF
) ();

    logic                start;
    logic                abort;
    logic [DATA_LEN-1:0] a;
    logic [DATA_LEN-1:0] b;
    logic [DATA_LEN-1:0] p;
    logic [DATA_LEN-1:0] result;
    logic                busy;
    logic                done;
    logic                err;
    state_t              state_dbg;

    modport master (
        output start, abort, a, b, p,
        input  result, busy, done, err, state_dbg
    );

    modport slave (
        input  start, abort, a, b, p,
        output result, busy, done, err, state_dbg
    );

endinterface

// File: rtl/moddiv_addsub.sv
// moddiv_addsub -- combinational modular helpers for one X register path.
//   x, y  : residues in [0, p-1]
//   p     : odd modulus
//   halve : x/2 mod p  (x>>1 when even, (x+p)>>1 when odd, DATA_LEN+1 bits)
//   sub   : (x - y) mod p (adds p back when the raw difference borrows)
module moddiv_addsub
    import moddiv_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF
) (
    input  logic [DATA_LEN-1:0] x,
    input  logic [DATA_LEN-1:0] y,
    input  logic [DATA_LEN-1:0] p,
    output logic [DATA_LEN-1:0] halve,
    output logic [DATA_LEN-1:0] sub
);

    logic [DATA_LEN:0]   sum;
    logic [DATA_LEN:0]   diff;
    logic [DATA_LEN-1:0] wrapped;
    logic                unused_lsb;

    // x odd and p odd make the sum even, so dropping bit 0 is exact.
    assign sum        = {1'b0, x} + (x[0] ? {1'b0, p} : '0);
    assign halve      = sum[DATA_LEN:1];
    assign unused_lsb = sum[0];

    // With x, y < p the corrected value lands in [0, p-1]; the carry out of
    // the modulo-2^DATA_LEN add cancels the borrow.
    assign diff    = {1'b0, x} - {1'b0, y};
    assign wrapped = diff[DATA_LEN-1:0] + p;
    assign sub     = diff[DATA_LEN] ? wrapped : diff[DATA_LEN-1:0];

endmodule

// File: rtl/moddiv_engine.sv
// moddiv_engine -- computes result = b * a^-1 mod p with the binary
// extended-Euclid method, one datapath step per LOOP cycle.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : moddiv_if slave (start/abort/a/b/p in; result/busy/done/err
//              and state_dbg out)
// err with done flags an out-of-range operand, a non-invertible a, or the
// LOOP watchdog expiring; result is 0 in those cases.
module moddiv_engine
    import moddiv_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int ITER_MAX = iter_max(DATA_LEN)
) (
    input  logic     clk,
    input  logic     rst,
    moddiv_if.slave  bus
);

    localparam int                  CNT_W   = $clog2(ITER_MAX + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(ITER_MAX);
    localparam logic [DATA_LEN-1:0] ONE     = DATA_LEN'(1);
    localparam logic [DATA_LEN-1:0] THREE   = DATA_LEN'(3);

    state_t              state;
    logic [DATA_LEN-1:0] a_r, b_r, p_r;
    logic [DATA_LEN-1:0] u, v, x1, x2;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_LEN-1:0] result_r;
    logic                busy_r, done_r, err_r;

    logic                range_fault;
    logic                term, term_ok;
    logic [DATA_LEN-1:0] term_val;
    step_t               step;

    logic [DATA_LEN-1:0] x1_half, x1_sub, x2_half, x2_sub;

    moddiv_addsub #(.DATA_LEN(DATA_LEN)) u_x1_path (
        .x     (x1),
        .y     (x2),
        .p     (p_r),
        .halve (x1_half),
        .sub   (x1_sub)
    );

    moddiv_addsub #(.DATA_LEN(DATA_LEN)) u_x2_path (
        .x     (x2),
        .y     (x1),
        .p     (p_r),
        .halve (x2_half),
        .sub   (x2_sub)
    );

    // Operand checks run on the captured copies during LOAD.
    assign range_fault = ~p_r[0] | (p_r < THREE) | (a_r >= p_r) | (b_r >= p_r);

    // Termination and step selection look only at registered U/V/counter.
    always_comb begin
        term     = 1'b0;
        term_ok  = 1'b0;
        term_val = '0;
        if (u == ONE) begin
            term     = 1'b1;
            term_ok  = 1'b1;
            term_val = x1;
        end else if (v == ONE) begin
            term     = 1'b1;
            term_ok  = 1'b1;
            term_val = x2;
        end else if ((u == '0) || (v == '0) || (cnt == CNT_MAX)) begin
            term     = 1'b1;
        end

        if (!u[0])        step = STEP_HALVE_U;
        else if (!v[0])   step = STEP_HALVE_V;
        else if (u >= v)  step = STEP_SUB_U;
        else              step = STEP_SUB_V;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            p_r      <= '0;
            u        <= '0;
            v        <= '0;
            x1       <= '0;
            x2       <= '0;
            cnt      <= '0;
            result_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    // abort is meaningless here, so start always wins.
                    if (bus.start) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        p_r    <= bus.p;
                        busy_r <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (range_fault) begin
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        err_r    <= 1'b1;
                        result_r <= '0;
                        state    <= ST_DONE;
                    end else begin
                        u     <= a_r;
                        v     <= p_r;
                        x1    <= b_r;
                        x2    <= '0;
                        cnt   <= '0;
                        state <= ST_LOOP;
                    end
                end
                ST_LOOP: begin
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (term) begin
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        err_r    <= ~term_ok;
                        result_r <= term_ok ? term_val : '0;
                        state    <= ST_DONE;
                    end else begin
                        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                        case (step)
                            STEP_HALVE_U: begin
                                u  <= u >> 1;
                                x1 <= x1_half;
                            end
                            STEP_HALVE_V: begin
                                v  <= v >> 1;
                                x2 <= x2_half;
                            end
                            STEP_SUB_U: begin
                                u  <= u - v;
                                x1 <= x1_sub;
                            end
                            default: begin
                                v  <= v - u;
                                x2 <= x2_sub;
                            end
                        endcase
                    end
                end
                default: begin
                    done_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.result    = result_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_moddiv_engine.sv
// tb_moddiv_engine -- self-checking bench for moddiv_engine at DATA_LEN=8.
// The reference model finds b/a mod p by exhaustive search over residues
// and decides err from the operand range rules and gcd(a, p).
module tb_moddiv_engine;
    import moddiv_pkg::*;

    localparam int DL    = 8;
    localparam int LIMIT = 200;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [DL:0] exp_q[$];

    moddiv_if #(.DATA_LEN(DL)) bus ();

    moddiv_engine #(.DATA_LEN(DL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic void model(input int a, input int b, input int p,
                                  output int res, output bit e);
        res = 0;
        e   = 1'b1;
        if ((p % 2 == 0) || (p < 3) || (a >= p) || (b >= p)) return;
        if (gcd(a, p) != 1) return;
        for (int x = 0; x < p; x++) begin
            if ((x * a) % p == b) begin
                res = x;
                e   = 1'b0;
            end
        end
    endfunction

    // Drives one request and waits for done; lat counts rising edges from
    // the accepting edge up to the cycle where done is seen.
    task automatic run_op(input int a, input int b, input int p,
                          output int res, output bit e, output int lat,
                          output bit ok);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = DL'(a);
        bus.b     = DL'(b);
        bus.p     = DL'(p);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        ok  = (bus.done === 1'b1);
        res = int'(bus.result);
        e   = bus.err;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.p     = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.result !== '0 ||
            bus.state_dbg !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b err=%b result=%0d state=%0d required all 0",
                     bus.busy, bus.done, bus.err, bus.result, bus.state_dbg);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        int res, lat, er;
        bit e, ok;
        int ta[6], tb_[6], tp[6], tr[6], te[6], tl[6];
        ta = '{3, 4, 1, 3, 3, 9};
        tb_ = '{1, 3, 5, 1, 1, 1};
        tp = '{7, 11, 11, 9, 8, 7};
        tr = '{5, 9, 5, 0, 0, 0};
        te = '{0, 0, 0, 1, 1, 1};
        tl = '{6, -1, 3, -1, 2, 2};
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb_[i], tp[i], res, e, lat, ok);
            er = int'(e);
            n_checks++;
            if (!ok || res != tr[i] || er != te[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] p=%0d a=%0d b=%0d: done=%b result=%0d err=%0d required result=%0d err=%0d",
                         i, tp[i], ta[i], tb_[i], ok, res, er, tr[i], te[i]);
            end
            if (tl[i] >= 0) begin
                n_checks++;
                if (lat != tl[i]) begin
                    n_fail++;
                    $display("FAIL latency[%0d]: got %0d cycles required %0d", i, lat, tl[i]);
                end
            end
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse[%0d]: done=%b one cycle later, required 0", i, bus.done);
            end
        end
    endtask

    task automatic test_abort;
        int res, lat, mres;
        bit e, ok, me, seen;
        run_op(3, 1, 7, res, e, lat, ok);
        // Abort during the first LOOP cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'd2;
        bus.b = 8'd1;
        bus.p = 8'd251;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 8'd5) begin
            n_fail++;
            $display("FAIL abort: busy=%b done=%b result=%0d required busy=0 done=0 result=5",
                     bus.busy, bus.done, bus.result);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen || bus.result !== 8'd5) begin
            n_fail++;
            $display("FAIL abort_quiet: done seen=%b result=%0d required no done, result=5",
                     seen, bus.result);
        end

        // A start pulse while busy must not replace the operation in flight.
        model(200, 1, 251, mres, me);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'd200;
        bus.b = 8'd1;
        bus.p = 8'd251;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'd3;
        bus.b = 8'd5;
        bus.p = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 3;
        while (bus.done !== 1'b1 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (bus.done !== 1'b1 || int'(bus.result) != mres || bus.err !== me) begin
            n_fail++;
            $display("FAIL start_while_busy: done=%b result=%0d err=%b required result=%0d err=%b",
                     bus.done, bus.result, bus.err, mres, me);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL start_queued: second done seen=%b required 0", seen);
        end

        // start and abort together in IDLE: the request is taken.
        model(4, 3, 11, mres, me);
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.a = 8'd4;
        bus.b = 8'd3;
        bus.p = 8'd11;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (bus.done !== 1'b1 || int'(bus.result) != mres || bus.err !== me) begin
            n_fail++;
            $display("FAIL start_with_abort: done=%b result=%0d err=%b required result=%0d err=%b",
                     bus.done, bus.result, bus.err, mres, me);
        end
    endtask

    task automatic test_rst_mid;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'd200;
        bus.b = 8'd1;
        bus.p = 8'd251;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.result !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: busy=%b done=%b err=%b result=%0d required all 0",
                     bus.busy, bus.done, bus.err, bus.result);
        end
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL rst_discard: done seen after reset, required none");
        end
    endtask

    task automatic test_random;
        int primes[16];
        int a, b, p, res, lat, mres;
        bit e, ok, me;
        logic [DL:0] exp;
        primes = '{251, 241, 239, 233, 229, 227, 211, 199, 193, 181, 157, 131, 101, 61, 13, 3};
        for (int i = 0; i < 60; i++) begin
            if (i % 4 == 3) p = 2 * int'($urandom_range(1, 127)) + 1;
            else            p = primes[$urandom_range(0, 15)];
            if (i % 4 == 0) begin
                a = int'($urandom_range(1, p - 1));
                b = int'($urandom_range(1, p - 1));
            end else begin
                a = int'($urandom_range(0, p - 1));
                b = int'($urandom_range(0, p - 1));
            end
            model(a, b, p, mres, me);
            exp_q.push_back({me, DL'(mres)});
            run_op(a, b, p, res, e, lat, ok);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok || e !== exp[DL] || res != int'(exp[DL-1:0])) begin
                n_fail++;
                $display("FAIL random[%0d] p=%0d a=%0d b=%0d: done=%b result=%0d err=%b required result=%0d err=%b",
                         i, p, a, b, ok, res, e, exp[DL-1:0], exp[DL]);
            end
            if (!e && ok) begin
                n_checks++;
                if ((res * a) % p != b) begin
                    n_fail++;
                    $display("FAIL random_identity[%0d]: result*a mod p=%0d required %0d",
                             i, (res * a) % p, b);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_abort();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
